// File: rtl/serdes_pkg.sv
// Shared serdes link definitions: header bit layout, frame FSM states and
// a clog2 helper used by the packetizer/depacketizer pair.
package serdes_pkg;

  localparam int unsigned HDR_VALID_BIT = 0;
  localparam int unsigned HDR_ID_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    DATA = 2'd2
  } serdes_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/packetizer_wide.sv
// Serializes one wide payload per handshake into a header/count/data frame
// of PACKET_WIDTH link words, gated at frame start by downstream almost-full.
module packetizer_wide
  import serdes_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 512,
  parameter int PACKET_WIDTH  = 16,
  parameter int ID            = 0,
  parameter     INST_NAME     = "packetizer_wide"
) (
  input  logic                     clk_packet,
  input  logic                     reset,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  input  logic                     payload_valid_i,
  output logic                     payload_ready_o,
  input  logic                     packet_af_i,
  output logic [PACKET_WIDTH-1:0]  packet_o,
  output logic                     frame_done_o,
  output logic                     busy_o
);

  localparam int N_DATA = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int N_PKTS = N_DATA + 1;
  localparam int BEAT_W = (clog2(N_DATA) > 0) ? int'(clog2(N_DATA)) : 1;

  localparam logic ID_BIT = (ID % 2) != 0;
  localparam logic [PACKET_WIDTH-1:0] HDR_WORD =
    (PACKET_WIDTH'(1) << HDR_VALID_BIT) | (PACKET_WIDTH'(ID_BIT) << HDR_ID_BIT);
  localparam logic [PACKET_WIDTH-1:0] CNT_WORD  = PACKET_WIDTH'(N_PKTS);
  localparam logic [BEAT_W-1:0]       BEAT_LAST = BEAT_W'(N_DATA - 1);

  if (PAYLOAD_WIDTH % PACKET_WIDTH != 0) begin : g_err_multiple
    $error("%s: PAYLOAD_WIDTH must be a multiple of PACKET_WIDTH", INST_NAME);
  end
  if (PACKET_WIDTH < 2) begin : g_err_width
    $error("%s: PACKET_WIDTH must be at least 2", INST_NAME);
  end
  if (N_DATA < 1) begin : g_err_ndata
    $error("%s: PAYLOAD_WIDTH must be at least PACKET_WIDTH", INST_NAME);
  end
  if ((N_PKTS >> PACKET_WIDTH) != 0) begin : g_err_count
    $error("%s: PACKET_WIDTH too narrow to hold the packet count", INST_NAME);
  end

  serdes_state_e              state_q;
  logic [PAYLOAD_WIDTH-1:0]   hold_q;
  logic                       hold_valid_q;
  logic [PAYLOAD_WIDTH-1:0]   shift_q;
  logic [BEAT_W-1:0]          beat_q;
  logic [PACKET_WIDTH-1:0]    packet_q;
  logic                       frame_done_q;

  logic accept;
  logic start;

  always_comb begin
    accept = payload_valid_i && !hold_valid_q;
    start  = (state_q == IDLE) && hold_valid_q && !packet_af_i;
  end

  // accept and start never coincide: accept needs an empty holding register,
  // start needs a full one, so the hold_valid_q update below is unambiguous.
  always_ff @(posedge clk_packet or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      beat_q       <= '0;
      packet_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (accept) begin
        hold_q       <= payload_i;
        hold_valid_q <= 1'b1;
      end else if (start) begin
        hold_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q  <= hold_q;
            packet_q <= HDR_WORD;
            state_q  <= CNT;
          end else begin
            packet_q <= '0;
          end
        end
        CNT: begin
          packet_q <= CNT_WORD;
          beat_q   <= '0;
          state_q  <= DATA;
        end
        DATA: begin
          packet_q <= shift_q[PACKET_WIDTH-1:0];
          shift_q  <= shift_q >> PACKET_WIDTH;
          if (beat_q == BEAT_LAST) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: begin
          packet_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign payload_ready_o = ~hold_valid_q;
  assign packet_o        = packet_q;
  assign frame_done_o    = frame_done_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: doc/packetizer_wide.md
# packetizer_wide

Wide-payload serializer on the transmit side of the serdes link. It accepts one PAYLOAD_WIDTH word per valid/ready handshake on clk_packet and emits it as a framed stream of PACKET_WIDTH words: a header word, a count word, then the data words, least-significant chunk first. It drives the packet input of the matching Depacketizer_wide instance directly and honours that block's almost-full backpressure.

## Interface
- PAYLOAD_WIDTH, 512, payload width; must be a multiple of PACKET_WIDTH (elaboration error otherwise)
- PACKET_WIDTH, 16, link word width; must be ≥ 2 and wide enough to hold N_PKTS
- ID, 0, destination id; only ID[0] is transmitted
- INST_NAME, "packetizer_wide", used in error messages
- clk_packet  in  1  link clock; all logic is on this clock
- reset  in  1  asynchronous, active-high
- payload_i  in  PAYLOAD_WIDTH  payload to send
- payload_valid_i  in  1  payload_i is valid
- payload_ready_o  out  1  block can accept a payload this cycle
- packet_af_i  in  1  downstream almost-full (depacketizer packet_af_o)
- packet_o  out  PACKET_WIDTH  link word, registered
- frame_done_o  out  1  one-cycle pulse while the last data word is on packet_o
- busy_o  out  1  a frame is in flight (state ≠ IDLE)

## Operation
- Derived constants: N_DATA = PAYLOAD_WIDTH/PACKET_WIDTH; N_PKTS = N_DATA+1.
- Frame on packet_o, one word per cycle:
  - Word 0, header: bit0 = 1 (valid), bit1 = ID[0], all other bits 0.
  - Word 1, count: N_PKTS, zero-extended.
  - Words 2..N_DATA+1: payload[k·PACKET_WIDTH +: PACKET_WIDTH] for k = 0..N_DATA-1.
- Idle word is all zeros; bit0 = 0 whenever no header is being sent.
- Holding register: a handshake (payload_valid_i && payload_ready_o) loads hold_reg and sets hold_valid. payload_ready_o = ~hold_valid.
- Frame start: in IDLE, when hold_valid && !packet_af_i:
  - hold_reg moves to shift_reg and hold_valid clears.
  - Header is registered onto packet_o.
  - State goes to CNT.
- FSM:
  - IDLE: packet_o ← header if starting a frame, else idle word.
  - CNT: packet_o ← count word; beat ← 0; go to DATA.
  - DATA: packet_o ← shift_reg low chunk; shift_reg shifts right by PACKET_WIDTH; beat increments. On beat == N_DATA-1, go to IDLE.
- Backpressure:
  - packet_af_i is sampled only at the frame-start decision.
  - Once a frame has started it always completes; the depacketizer cannot stall mid-frame.
  - When af is low, downstream has room for one full payload.
- Back-to-back frames: the IDLE cycle after the last data word may itself emit the next header. This matches the depacketizer's free trailing slot. Minimum frame period is N_DATA+2 cycles.
- A new payload may be accepted while a frame is in flight, because the holding register is freed at frame start.

## Timing
- Reset values (asynchronous): state = IDLE, packet_o = 0, hold_valid = 0, payload_ready_o = 1, frame_done_o = 0, busy_o = 0.
- Reset mid-frame aborts immediately: packet_o drops to 0 and any held payload is discarded. The depacketizer shares this reset.
- Payload accepted at edge e → header on packet_o after edge e+1, if packet_af_i is low at e+1.
- Count word is on packet_o after e+2; last data word after e+N_DATA+2, with frame_done_o high for exactly that cycle.
- If packet_af_i is high, the block stays in IDLE emitting idle words and holding the payload. payload_ready_o stays 0 while hold_valid is set.
- Simultaneous frame start and new handshake in the same cycle is not possible, since ready is 0 while hold_valid is set. The new payload is accepted on the cycle after the start.
- The beat counter is clog2(N_DATA) bits wide and never wraps past N_DATA-1.

## Structure
- Shared package serdes_pkg holds:
  - the clog2 function;
  - header bit positions (HDR_VALID_BIT = 0, HDR_ID_BIT = 1);
  - state encoding (IDLE, CNT, DATA).
- Depacketizer_wide uses the same package constants.
- No sub-module: the holding register, shift register, counter and FSM stay inline.

## Test plan
All scenarios use the default parameters: N_DATA = 32, count word = 0x0021.
- Single payload 0x…0003_0002_0001 with ID=0 → packet_o sequence 0x0001, 0x0021, 0x0001, 0x0002, 0x0003, …, 32 data words total, then 0x0000. frame_done_o is high on the 32nd data word.
- ID=1, two payloads offered back-to-back → second header 0x0003 appears on the cycle right after the first frame's last data word; period is 34 cycles.
- packet_af_i held high for 10 cycles with a payload held → 10 idle words and payload_ready_o = 0. Header appears on the cycle after af falls.
- packet_af_i rises during a DATA state → frame still completes all 32 data words uninterrupted.
- Reset asserted at data word 5 → packet_o = 0 immediately and payload_ready_o = 1. A new payload then produces a clean full frame.
- End-to-end with Depacketizer_wide (ID match), random payloads at maximum rate → every payload_o equals the sent payload, in order, with none dropped.
